// File: rtl/tlp_xcvr_pkg.sv
// Shared types, register map and generator step for the C2F stream checker.
// DEFAULT_SEED stands in whenever the programmed seed is zero, because xorshift never leaves state zero.
package tlp_xcvr_pkg;

    localparam int CHAN_WIDTH = 8;

    typedef logic [CHAN_WIDTH-1:0] Channel;
    typedef logic [31:0]           Data;
    typedef logic [63:0]           uint64;

    localparam uint64 DEFAULT_SEED = 64'h0123456789ABCDEF;

    localparam logic [2:0] OFF_CTRL      = 3'd0;
    localparam logic [2:0] OFF_SEED_LO   = 3'd1;
    localparam logic [2:0] OFF_SEED_HI   = 3'd2;
    localparam logic [2:0] OFF_LEN       = 3'd3;
    localparam logic [2:0] OFF_STATUS    = 3'd4;
    localparam logic [2:0] OFF_WORDS     = 3'd5;
    localparam logic [2:0] OFF_ERRS      = 3'd6;
    localparam logic [2:0] OFF_FIRST_ERR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    function automatic uint64 xorshift64(uint64 x);
        uint64 y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

endpackage

// File: rtl/c2f_checker_if.sv
// Stream and register-bus signals of the C2F checker, bundled with the DUT side as the slave modport.
// Signal names carry the established bus names so host-side wrappers connect unchanged.
interface c2f_checker_if;
    import tlp_xcvr_pkg::*;

    uint64  c2fData_in;
    logic   c2fValid_in;
    Channel cpuChan_in;
    Data    cpuWrData_in;
    logic   cpuWrValid_in;
    logic   cpuWrReady_out;
    Data    cpuRdData_out;
    logic   cpuRdValid_out;
    logic   busy_out;
    logic   errPulse_out;

    modport master (
        output c2fData_in,
        output c2fValid_in,
        output cpuChan_in,
        output cpuWrData_in,
        output cpuWrValid_in,
        input  cpuWrReady_out,
        input  cpuRdData_out,
        input  cpuRdValid_out,
        input  busy_out,
        input  errPulse_out
    );

    modport slave (
        input  c2fData_in,
        input  c2fValid_in,
        input  cpuChan_in,
        input  cpuWrData_in,
        input  cpuWrValid_in,
        output cpuWrReady_out,
        output cpuRdData_out,
        output cpuRdValid_out,
        output busy_out,
        output errPulse_out
    );

endinterface

// File: rtl/c2f_prbs64.sv
// Expected-data generator: 64-bit xorshift with registered output.
// load has priority over advance so a restart never sees a stale step.
module c2f_prbs64
    import tlp_xcvr_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  uint64 seed,
    input  logic  advance,
    output uint64 value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= xorshift64(value);
        end
    end

endmodule

// File: rtl/c2f_checker.sv
// C2F stream checker: compares DMA beats with an xorshift sequence and reports via an
// eight-channel register window starting at BASE_CHAN.
//
//   state | meaning
//   IDLE  | waiting for start; beats ignored
//   RUN   | checking beats against the generator
//   PASS  | LEN words seen, no mismatches
//   FAIL  | LEN words seen, at least one mismatch
module c2f_checker
    import tlp_xcvr_pkg::*;
#(
    parameter bit EN_SWAP   = 1'b0,
    parameter int BASE_CHAN = 240
) (
    input logic          pcieClk_in,
    input logic          reset_in,
    c2f_checker_if.slave bus
);

    localparam Channel BASE = Channel'(BASE_CHAN);

    state_t state_q;
    state_t state_next;

    Data seed_lo_q;
    Data seed_hi_q;
    Data len_q;
    Data words_q;
    Data errs_q;
    Data first_err_q;
    logic err_pulse_q;

    Channel     rel;
    logic       in_win;
    logic [2:0] off;
    logic       wr_hit;
    logic       start;
    logic       abort;
    Data        len_eff;
    logic       beat;
    logic       mismatch;
    Data        errs_next;
    logic       done;
    uint64      seed_cfg;
    uint64      expected;
    Data        rd_data;
    logic       busy;

    assign rel    = bus.cpuChan_in - BASE;
    assign in_win = (bus.cpuChan_in >= BASE) && (rel[CHAN_WIDTH-1:3] == '0);
    assign off    = rel[2:0];
    assign wr_hit = bus.cpuWrValid_in && in_win;

    // Start outranks abort when both bits land in one write.
    assign start = wr_hit && (off == OFF_CTRL) && bus.cpuWrData_in[0];
    assign abort = wr_hit && (off == OFF_CTRL) && bus.cpuWrData_in[1] && !bus.cpuWrData_in[0];

    // A LEN write counts toward the beat arriving in the same cycle.
    assign len_eff = (wr_hit && (off == OFF_LEN)) ? bus.cpuWrData_in : len_q;

    assign busy      = (state_q == ST_RUN);
    assign beat      = bus.c2fValid_in && busy && !start && !abort;
    assign mismatch  = beat && (bus.c2fData_in != expected);
    assign errs_next = (mismatch && (errs_q != '1)) ? errs_q + 32'd1 : errs_q;
    assign done      = beat && (len_eff != '0) &&
                       (({1'b0, words_q} + 33'd1) >= {1'b0, len_eff});

    assign seed_cfg = ({seed_hi_q, seed_lo_q} == '0) ? DEFAULT_SEED : {seed_hi_q, seed_lo_q};

    c2f_prbs64 u_prbs (
        .clk     (pcieClk_in),
        .rst     (reset_in),
        .load    (start),
        .seed    (seed_cfg),
        .advance (beat),
        .value   (expected)
    );

    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (start) begin
            state_next = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (abort) begin
                state_next = ST_IDLE;
            end else if (done) begin
                state_next = (errs_next == '0) ? ST_PASS : ST_FAIL;
            end
        end
    end

    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            seed_lo_q   <= '0;
            seed_hi_q   <= '0;
            len_q       <= '0;
            words_q     <= '0;
            errs_q      <= '0;
            first_err_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= mismatch;
            if (wr_hit) begin
                case (off)
                    OFF_SEED_LO: seed_lo_q <= bus.cpuWrData_in;
                    OFF_SEED_HI: seed_hi_q <= bus.cpuWrData_in;
                    OFF_LEN:     len_q     <= bus.cpuWrData_in;
                    default:     ;
                endcase
            end
            if (start) begin
                words_q     <= '0;
                errs_q      <= '0;
                first_err_q <= '0;
            end else if (beat) begin
                words_q <= words_q + 32'd1;
                errs_q  <= errs_next;
                if (mismatch && (errs_q == '0)) begin
                    first_err_q <= words_q;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_win) begin
            case (off)
                OFF_SEED_LO:   rd_data = seed_lo_q;
                OFF_SEED_HI:   rd_data = seed_hi_q;
                OFF_LEN:       rd_data = len_q;
                OFF_STATUS:    rd_data = {28'd0, state_q, (errs_q != '0), busy};
                OFF_WORDS:     rd_data = words_q;
                OFF_ERRS:      rd_data = errs_q;
                OFF_FIRST_ERR: rd_data = first_err_q;
                default:       rd_data = '0;
            endcase
        end
    end

    assign bus.cpuRdData_out  = EN_SWAP ? {rd_data[15:0], rd_data[31:16]} : rd_data;
    assign bus.cpuWrReady_out = 1'b1;
    assign bus.cpuRdValid_out = 1'b1;
    assign bus.busy_out       = busy;
    assign bus.errPulse_out   = err_pulse_q;

endmodule

// File: doc/c2f_checker.md
C2F_CHECKER -- requirements
Module: c2f_checker

Interface
REQ-001 Parameter EN_SWAP, default 0: when 1, cpuRdData_out returns its 16-bit halves swapped.
REQ-002 Parameter BASE_CHAN, default 240: first of eight consecutive register channels owned by the block.
REQ-003 pcieClk_in  in  1  the only clock, 125MHz.
REQ-004 reset_in  in  1  reset, synchronous to pcieClk_in, active-high.
REQ-005 c2fData_in  in  64  CPU->FPGA DMA stream data.
REQ-006 c2fValid_in  in  1  stream beat valid; there is no backpressure.
REQ-007 cpuChan_in  in  CHAN_WIDTH  register channel.
REQ-008 cpuWrData_in  in  32  register write data.
REQ-009 cpuWrValid_in  in  1  register write strobe.
REQ-010 cpuWrReady_out  out  1  always 1.
REQ-011 cpuRdData_out  out  32  register read data, combinational from cpuChan_in.
REQ-012 cpuRdValid_out  out  1  always 1.
REQ-013 busy_out  out  1  high in RUN.
REQ-014 errPulse_out  out  1  one-cycle pulse on each mismatching beat.

Function
REQ-015 Registers at offsets from BASE_CHAN: 0 CTRL (write-only; bit0 = start, bit1 = abort), 1 SEED_LO, 2 SEED_HI, 3 LEN (expected word count; 0 = unlimited), 4 STATUS (read-only), 5 WORDS, 6 ERRS, 7 FIRST_ERR.
REQ-016 Channels outside the window read as 0; writes to them and to read-only offsets are ignored.
REQ-017 STATUS reads {28'b0, state[1:0], 1'b(ERRS!=0), busy}.
REQ-018 States are IDLE, RUN, PASS and FAIL; reset enters IDLE.
REQ-019 Start from any state: expected word loads with {SEED_HI,SEED_LO}, or DEFAULT_SEED when the seed is 0; WORDS, ERRS and FIRST_ERR clear; the next state is RUN.
REQ-020 Abort in RUN leads to IDLE with counters preserved; abort in other states is ignored.
REQ-021 If start and abort are set in the same write, start wins.
REQ-022 In RUN, each valid beat compares c2fData_in with the expected word, advances the generator, and increments WORDS; all updates are registered and visible the next cycle.
REQ-023 Generator step is 64-bit xorshift: x^=x<<13; x^=x>>7; x^=x<<17. The first expected word is the seed itself.
REQ-024 On a mismatch: ERRS increments, saturating at 0xFFFFFFFF; errPulse_out pulses in the following cycle; FIRST_ERR latches the pre-increment WORDS only when ERRS was 0.
REQ-025 When LEN≠0 and the beat completes WORDS==LEN: next state is PASS if no errors (including this beat), else FAIL.
REQ-026 When LEN=0, the block stays in RUN until abort; WORDS wraps modulo 2^32.
REQ-027 Valid beats in IDLE, PASS or FAIL are ignored.
REQ-028 A valid beat coincident with a start write is discarded; the new run begins with the next beat.
REQ-029 A LEN write during RUN takes effect immediately; if WORDS is already ≥ the new nonzero LEN, the next beat terminates the run.

Reset
REQ-030 Reset values: state IDLE; SEED, LEN, WORDS, ERRS and FIRST_ERR 0; busy_out 0; errPulse_out 0.
REQ-031 Reset asserted mid-run overrides every concurrent write and beat.

Structure
REQ-032 DEFAULT_SEED (64'h0123456789ABCDEF), the register offset constants and the state enum belong in tlp_xcvr_pkg, alongside Channel, Data and uint64.
REQ-033 The expected-data generator is a sub-module, c2f_prbs64, with inputs load, seed and advance and a registered 64-bit output.

Verification
REQ-034 Seed=1, LEN=2, start, beats 0x1 then 0x40822041 -> PASS, WORDS=2, ERRS=0.
REQ-035 Seed=1, LEN=3, beats 0x1, 0x0, then the correct third word -> FAIL, ERRS=1, FIRST_ERR=1, one errPulse.
REQ-036 Seed=0, LEN=1, beat 0x0123456789ABCDEF -> PASS.
REQ-037 LEN=0, 5 correct beats, abort -> IDLE, WORDS=5; a further beat leaves WORDS=5.
REQ-038 Start write coincident with a valid beat of 0x1 (seed=1), then beat 0x1 -> WORDS=1, ERRS=0.
REQ-039 EN_SWAP=1, read WORDS=0x00000005 -> cpuRdData_out=0x00050000; reset mid-RUN -> IDLE, all counters 0.
